// File: rtl/ps2_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo_pkg
// Description : PS/2 frame constants, scan codes and deframer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package ps2_rx_fifo_pkg;

    localparam int         c_frame_bits = 11;
    localparam logic       c_start_bit  = 1'b0;
    localparam logic       c_stop_bit   = 1'b1;
    localparam logic [3:0] c_last_bit   = 4'(c_frame_bits - 1);

    // Scan codes consumed by the keyboard FSM downstream
    localparam logic [7:0] c_sc_break   = 8'hF0;
    localparam logic [7:0] c_sc_extend  = 8'hE0;

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_shift   = 1'b1;

endpackage : ps2_rx_fifo_pkg
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_fifo
// Description : Show-ahead synchronous FIFO; a push while full is dropped
//               unless a pop happens in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          push_drop
);

    localparam int c_depth = 2 ** AW;

    logic [DW-1:0] r_mem [c_depth];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_pop;
    logic          w_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign w_pop     = pop & ~empty;
    assign w_push    = push & (~full | w_pop);
    assign push_drop = push & full & ~w_pop;

    assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : ps2_sync_fifo
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver: oversampling synchroniser,
//               11-bit deframer with timeout resync, and scan-code FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic       sampling
);

    localparam int                 c_tmo_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYC);

    logic [2:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_buf;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_wr_req;
    logic [7:0]         r_wr_data;
    logic               r_frame_err;
    logic               r_overflow;

    logic w_fall;
    logic w_bit;
    logic w_last;
    logic w_tmo_hit;
    logic w_frame_ok;
    logic w_check;
    logic w_abort;
    logic w_tmo_run;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_drop;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit      = r_data_sync[1];
    assign w_last     = (r_bit_cnt == c_last_bit);
    assign w_tmo_hit  = (r_tmo_cnt == c_tmo_max) & ~w_fall;
    // w_bit is the stop bit on the final edge; r_buf[9:1] is data plus parity
    assign w_frame_ok = (r_buf[0] == c_start_bit) & (w_bit == c_stop_bit) & (^r_buf[9:1]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_fall)                          w_state_nxt = c_st_shift;
            c_st_shift: if ((w_fall && w_last) || w_tmo_hit) w_state_nxt = c_st_idle;
            default:                                         w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_check   = 1'b0;
        w_abort   = 1'b0;
        w_tmo_run = 1'b0;
        if (r_state == c_st_shift) begin
            w_check   = w_fall & w_last;
            w_abort   = w_tmo_hit;
            w_tmo_run = ~w_fall;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt   <= '0;
            r_buf       <= '0;
            r_tmo_cnt   <= '0;
            r_wr_req    <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_req    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_check) begin
                r_bit_cnt <= '0;
                if (w_frame_ok) begin
                    r_wr_req  <= 1'b1;
                    r_wr_data <= r_buf[8:1];
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_fall) begin
                r_buf[r_bit_cnt] <= w_bit;
                r_bit_cnt        <= r_bit_cnt + 1'b1;
            end else if (w_abort) begin
                r_bit_cnt <= '0;
            end
            r_tmo_cnt <= w_tmo_run ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    assign w_pop = ~nextdata_n & ~w_empty;

    ps2_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (r_wr_req),
        .pop       (w_pop),
        .din       (r_wr_data),
        .dout      (data),
        .empty     (w_empty),
        .full      (w_full),
        .push_drop (w_push_drop)
    );

    // A dropped push never coincides with a pop, so set and clear are exclusive
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end else if (w_pop) begin
            r_overflow <= 1'b0;
        end
    end

    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign sampling  = w_fall;

endmodule : ps2_rx_fifo
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for the PS/2 receiver FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_rx_fifo;
    import ps2_rx_fifo_pkg::*;

    localparam int c_tmo  = 300;
    localparam int c_half = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic       sampling;

    int n_vec  = 0;
    int n_fail = 0;
    int samp_cnt = 0;
    int ferr_cnt = 0;

    ps2_rx_fifo #(
        .FIFO_AW     (3),
        .TIMEOUT_CYC (c_tmo)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .sampling   (sampling)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sampling)  samp_cnt = samp_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (c_half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (c_half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(make_frame(d, 1'b0, 1'b0), 11);
    endtask

    task automatic do_pop();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (data !== 8'h00)    begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        n_vec++; if (ready !== 1'b0)    begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_vec++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_vec++; if (sampling !== 1'b0) begin n_fail++; $display("FAIL reset_sampling got %b want 0", sampling); end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int s0, f0;
        s0 = samp_cnt; f0 = ferr_cnt;
        send_byte(8'h1C);
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", ready); end
        n_vec++; if (data !== 8'h1C) begin n_fail++; $display("FAIL single_data got %h want 1c", data); end
        n_vec++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", ferr_cnt - f0); end
        n_vec++; if (samp_cnt - s0 != 11) begin n_fail++; $display("FAIL single_sampling got %0d want 11", samp_cnt - s0); end
        do_pop();
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL single_pop_ready got %b want 0", ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h1C; exp[1] = c_sc_break; exp[2] = 8'h1C;
        for (int i = 0; i < 3; i++) send_byte(exp[i]);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (data !== exp[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, data, exp[i]); end
            do_pop();
        end
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %b want 0", ready); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b want 0", overflow); end
        send_byte(8'h99);
        n_vec++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_vec++; if (data !== 8'h10) begin n_fail++; $display("FAIL ovf_head got %h want 10", data); end
        do_pop();
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready got %b want 1", ready); end
        for (int i = 1; i < 8; i++) begin
            n_vec++; if (data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, data, 8'h10 + 8'(i)); end
            do_pop();
        end
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", ready); end
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11);
        n_vec++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_parity_pulses got %0d want 1", ferr_cnt - f0); end
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ferr_parity_ready got %b want 0", ready); end
        f0 = ferr_cnt;
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
        n_vec++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_stop_pulses got %0d want 1", ferr_cnt - f0); end
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ferr_stop_ready got %b want 0", ready); end
        // Pop requests on an empty FIFO must not move the read pointer
        nextdata_n = 1'b0;
        repeat (4) @(negedge clk);
        nextdata_n = 1'b1;
        send_byte(8'h33);
        n_vec++; if (data !== 8'h33 || ready !== 1'b1) begin n_fail++; $display("FAIL empty_pop got %h/%b want 33/1", data, ready); end
        do_pop();
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL empty_pop_after got %b want 0", ready); end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = ferr_cnt;
        send_bits(make_frame(8'h55, 1'b0, 1'b0), 5);
        repeat (c_tmo + 50) @(negedge clk);
        send_byte(8'h2A);
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready got %b want 1", ready); end
        n_vec++; if (data !== 8'h2A) begin n_fail++; $display("FAIL tmo_data got %h want 2a", data); end
        n_vec++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL tmo_frame_err got %0d want 0", ferr_cnt - f0); end
        do_pop();
    endtask

    task automatic test_clrn_midframe();
        for (int i = 0; i < 3; i++) send_byte(c_sc_extend + 8'(i));
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ready got %b want 1", ready); end
        send_bits(make_frame(8'hAA, 1'b0, 1'b0), 4);
        #2 clrn = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0", ready); end
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow got %b want 0", overflow); end
        n_vec++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got %h want 00", data); end
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h5A);
        n_vec++; if (ready !== 1'b1 || data !== 8'h5A) begin n_fail++; $display("FAIL rst_after got %h/%b want 5a/1", data, ready); end
        do_pop();
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_after_pop got %b want 0", ready); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_frame_err();
        test_timeout();
        test_clrn_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_ps2_rx_fifo
`default_nettype wire
